// File: rtl/uart_ctrl.sv
// uart_ctrl: parametrised full-duplex UART with baud divider, synchronised mid-bit receiver and valid/ready transmitter.
// Define UART_PARITY_EN to add an even-parity bit to both directions and the rx_parity_err output.
module uart_ctrl #(
    parameter int BAUD_DIV  = 10417,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 fclk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
`ifdef UART_PARITY_EN
    output logic                 rx_parity_err,
`endif
    output logic                 rx_overrun
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    state_t               r_tx_state, w_tx_state;
    logic [15:0]          r_tx_cnt, w_tx_cnt;
    logic [3:0]           r_tx_bit, w_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
    logic                 r_tx, w_tx_line, r_tx_ready;
    logic                 w_tx_end;
`ifdef UART_PARITY_EN
    logic                 r_tx_par;
`endif

    state_t               r_rx_state, w_rx_state;
    logic [15:0]          r_rx_cnt, w_rx_cnt;
    logic [3:0]           r_rx_bit, w_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
    logic                 r_rx_s1, r_rx_s2;
    logic                 r_rx_stop, w_rx_stop;
    logic                 r_rx_done, w_rx_done;
    logic                 w_rx_end;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_rx_ferr, r_rx_ovr;
`ifdef UART_PARITY_EN
    logic                 r_rx_par_bit, w_rx_par_bit;
    logic                 r_rx_perr;
`endif

    assign w_tx_end = (r_tx_cnt == BAUD_LAST);
    assign w_rx_end = (r_rx_cnt == BAUD_LAST);

    // TX next state; w_tx_line is the value tx takes after this edge
    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = r_tx_cnt;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_tx_line  = 1'b1;
        case (r_tx_state)
            S_IDLE: begin
                if (tx_valid && r_tx_ready) begin
                    w_tx_state = S_START;
                    w_tx_cnt   = 16'd0;
                    w_tx_shift = tx_data;
                    w_tx_line  = 1'b0;
                end else begin
                    w_tx_line  = 1'b1;
                end
            end
            S_START: begin
                w_tx_line = 1'b0;
                if (w_tx_end) begin
                    w_tx_state = S_DATA;
                    w_tx_cnt   = 16'd0;
                    w_tx_bit   = 4'd0;
                    w_tx_line  = r_tx_shift[0];
                end else begin
                    w_tx_cnt   = r_tx_cnt + 16'd1;
                end
            end
            S_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_end) begin
                    w_tx_cnt   = 16'd0;
                    w_tx_shift = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    if (r_tx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        w_tx_state = S_PARITY;
                        w_tx_line  = r_tx_par;
`else
                        w_tx_state = S_STOP;
                        w_tx_bit   = 4'd0;
                        w_tx_line  = 1'b1;
`endif
                    end else begin
                        w_tx_bit   = r_tx_bit + 4'd1;
                        w_tx_line  = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt   = r_tx_cnt + 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                w_tx_line = r_tx_par;
                if (w_tx_end) begin
                    w_tx_state = S_STOP;
                    w_tx_cnt   = 16'd0;
                    w_tx_bit   = 4'd0;
                    w_tx_line  = 1'b1;
                end else begin
                    w_tx_cnt   = r_tx_cnt + 16'd1;
                end
            end
`endif
            S_STOP: begin
                w_tx_line = 1'b1;
                if (w_tx_end) begin
                    w_tx_cnt = 16'd0;
                    if (r_tx_bit == STOP_LAST) begin
                        w_tx_state = S_IDLE;
                    end else begin
                        w_tx_bit   = r_tx_bit + 4'd1;
                    end
                end else begin
                    w_tx_cnt = r_tx_cnt + 16'd1;
                end
            end
            default: begin
                w_tx_state = S_IDLE;
            end
        endcase
    end

    // TX state register and registered line/ready outputs
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 4'd0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_tx       <= w_tx_line;
            r_tx_ready <= (w_tx_state == S_IDLE);
`ifdef UART_PARITY_EN
            if (r_tx_state == S_IDLE && tx_valid && r_tx_ready) begin
                r_tx_par <= even_parity(tx_data);
            end
`endif
        end
    end

    // RX next state; the counter starts at 1 on detection so the start sample lands BAUD_DIV/2 after the synchronised fall
    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_cnt   = r_rx_cnt;
        w_rx_bit   = r_rx_bit;
        w_rx_shift = r_rx_shift;
        w_rx_stop  = r_rx_stop;
        w_rx_done  = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_bit = r_rx_par_bit;
`endif
        case (r_rx_state)
            S_IDLE: begin
                if (!r_rx_s2) begin
                    w_rx_state = S_START;
                    w_rx_cnt   = 16'd1;
                end else begin
                    w_rx_cnt   = 16'd0;
                end
            end
            S_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt   = 16'd0;
                    w_rx_bit   = 4'd0;
                    w_rx_state = r_rx_s2 ? S_IDLE : S_DATA;
                end else begin
                    w_rx_cnt   = r_rx_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_rx_end) begin
                    w_rx_cnt   = 16'd0;
                    w_rx_shift = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        w_rx_state = S_PARITY;
`else
                        w_rx_state = S_STOP;
`endif
                    end else begin
                        w_rx_bit   = r_rx_bit + 4'd1;
                    end
                end else begin
                    w_rx_cnt   = r_rx_cnt + 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_rx_end) begin
                    w_rx_cnt     = 16'd0;
                    w_rx_par_bit = r_rx_s2;
                    w_rx_state   = S_STOP;
                end else begin
                    w_rx_cnt     = r_rx_cnt + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_rx_end) begin
                    w_rx_cnt   = 16'd0;
                    w_rx_stop  = r_rx_s2;
                    w_rx_done  = 1'b1;
                    w_rx_state = S_IDLE;
                end else begin
                    w_rx_cnt   = r_rx_cnt + 16'd1;
                end
            end
            default: begin
                w_rx_state = S_IDLE;
            end
        endcase
    end

    // RX synchroniser and state register
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 4'd0;
            r_rx_shift <= '0;
            r_rx_stop  <= 1'b1;
            r_rx_done  <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bit <= 1'b0;
`endif
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_state <= w_rx_state;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_bit   <= w_rx_bit;
            r_rx_shift <= w_rx_shift;
            r_rx_stop  <= w_rx_stop;
            r_rx_done  <= w_rx_done;
`ifdef UART_PARITY_EN
            r_rx_par_bit <= w_rx_par_bit;
`endif
        end
    end

    // RX handshake: a completion with a same-cycle ack is a consume then a load, so no overrun
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_ovr   <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_perr  <= 1'b0;
`endif
        end else if (r_rx_done) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            r_rx_ferr  <= ~r_rx_stop;
            r_rx_ovr   <= r_rx_valid & ~rx_ready;
`ifdef UART_PARITY_EN
            r_rx_perr  <= even_parity(r_rx_shift) ^ r_rx_par_bit;
`endif
        end else begin
            r_rx_ovr   <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign tx           = r_tx;
    assign tx_ready     = r_tx_ready;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_ferr;
    assign rx_overrun   = r_rx_ovr;
`ifdef UART_PARITY_EN
    assign rx_parity_err = r_rx_perr;
`endif

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Parametrised full-duplex UART, successor to the fixed 8N1 engine. One block holds the baud divider, a mid-bit-sampling receiver with a 2-flop synchroniser, start-glitch rejection and framing/overrun detection, and a valid/ready transmitter. It sits between the board serial pins and the host-command logic, and runs entirely on `fclk` without an external bit-rate strobe.

## Interface
- `BAUD_DIV`, default 10417: `fclk` cycles per bit. Legal range is 4..65535; 10417 gives 9600 baud at 100 MHz.
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5..9; bits are sent LSB first.
- `STOP_BITS`, default 1: stop bits the transmitter sends. Legal values are 1 and 2.
- `fclk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `tx_data` in DATA_BITS: byte to send. Sampled at the accept cycle.
- `tx_valid` in 1: transmit request.
- `tx_ready` out 1: high when the transmitter is idle and can accept a byte.
- `tx` out 1: serial output. Idles high.
- `rx` in 1: asynchronous serial input.
- `rx_data` out DATA_BITS: last received byte.
- `rx_valid` out 1: high while `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer acknowledge.
- `rx_frame_err` out 1: stop bit sampled low. Valid while `rx_valid` is high.
- `rx_overrun` out 1: one-cycle pulse when an unconsumed byte is overwritten.

## Operation
- **Reset values:** `tx`=1, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0. Both FSMs go to IDLE and all counters clear.
- **Reset mid-frame:** aborts at once. `tx` returns high and no partial byte is reported.
- **TX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - Accept: `tx_valid && tx_ready` in IDLE. `tx_data` is latched into a shift register and `tx_ready` drops the next cycle.
  - A bit counter holds each state for `BAUD_DIV` cycles.
  - DATA runs `DATA_BITS` bit periods.
  - STOP runs `STOP_BITS` bit periods with `tx`=1.
  - Changes to `tx_data` after the accept cycle have no effect on the frame in progress.
- **RX front end:** `rx` passes through 2 flops before any use, so the synchroniser adds 2 cycles of latency.
- **RX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: the synchronised `rx` low starts the counter and moves to START.
  - START: at `BAUD_DIV/2` (integer divide), `rx` must still be low, else return to IDLE (glitch rejected, nothing reported).
  - DATA and STOP: one sample every `BAUD_DIV` cycles after the mid-start sample.
  - STOP: only one stop bit is checked, whatever `STOP_BITS` is. A low stop bit sets `rx_frame_err`=1; the byte is still delivered.
  - The FSM returns to IDLE in the cycle after the stop sample, i.e. mid stop bit, so back-to-back frames are caught.
- **RX handshake:**
  - Cycle after the stop sample: `rx_data` and the error flags load, and `rx_valid` is set.
  - `rx_valid && rx_ready` clears `rx_valid` on the next edge. `rx_data` holds its value.
  - Completion while `rx_valid`=1 and not acked in the same cycle: new data overwrites and `rx_overrun` pulses for 1 cycle.
  - Completion and ack in the same cycle: treated as a consume followed by a load. `rx_valid` stays 1 and there is no overrun.
- TX and RX are fully independent and may run simultaneously.

## Timing
- Accept to `tx` falling: 1 cycle.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) × BAUD_DIV cycles, where P=1 with parity compiled in, else 0.
- `tx_ready` rises F cycles after `tx` falls.
- Back-to-back transmit: with `tx_valid` held high, the next start bit begins 1 cycle after `tx_ready` rises. The inter-frame idle gap is exactly 1 cycle.
- RX latency from the `rx` pin's falling edge to `rx_valid` = 2 + BAUD_DIV/2 + (DATA_BITS + P + 1) × BAUD_DIV + 1 cycles.
- Glitch rejection: a low pulse is rejected if it is shorter than BAUD_DIV/2 cycles as seen after the synchroniser.

## Configuration
- Macro `UART_PARITY_EN`, when defined:
  - TX inserts an even-parity bit (XOR of the data bits) after DATA.
  - RX samples the parity bit and adds output `rx_parity_err`, which goes to 1 on mismatch, resets to 0 and is valid with `rx_valid`.
- Macro undefined: no parity state exists, P=0, and the `rx_parity_err` port is absent.

## Test plan
- BAUD_DIV=16, DATA_BITS=8, send 0xA5:
  - `tx` reads 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each bit lasts 16 cycles, and `tx_ready` low for 160 cycles (176 with `UART_PARITY_EN`).
- Loopback `tx`→`rx`, send 0x00, 0xFF and 0x3C back-to-back with `rx_ready`=1:
  - `rx_valid` pulses 3 times with matching data.
  - `rx_frame_err`=0 on all three, and the TX idle gap is 1 cycle.
- Drive `rx` low for 5 cycles with BAUD_DIV=16: no `rx_valid`, and the RX FSM is back in IDLE.
- Drive the frame 0x5A with the stop bit forced low: `rx_valid`=1, `rx_data`=0x5A, `rx_frame_err`=1.
- Hold `rx_ready`=0 and receive 0x11 then 0x22: `rx_overrun` pulses once and `rx_data`=0x22.
- With `UART_PARITY_EN`, receive 0x07 with the parity bit set to 0 (wrong; 0x07 has odd weight): `rx_parity_err`=1. Assert `rst` mid-frame: `tx`=1 and `tx_ready`=1 at once, and no `rx_valid`.
